// File: rtl/ghostbus_byte_host.sv
// Byte-stream command host for the ghostbus: parses write/read frames from rx,
// issues one bus strobe per frame and streams the ack or read data back on tx.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for an opcode byte
// S_ADDR  | shifting in address bytes, MSB first
// S_WDATA | shifting in write-data bytes, MSB first
// S_WRITE | gb_we asserted for this single cycle
// S_READ  | gb_re asserted for this single cycle
// S_WAIT  | counting down the bus read latency
// S_TX    | streaming the captured read word, MSB first
// S_ACK   | holding 0xA5 write acknowledge until accepted
// S_ERR   | holding 0xEE bad-opcode response until accepted
module ghostbus_byte_host #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_we,
    output logic          gb_re,
    input  logic [DW-1:0] gb_rdata,
    output logic          busy
);

    localparam int AB = AW / 8;
    localparam int DB = DW / 8;
    localparam logic [7:0] OP_WR   = 8'h01;
    localparam logic [7:0] OP_RD   = 8'h02;
    localparam logic [7:0] RSP_ACK = 8'hA5;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_READ, S_WAIT, S_TX, S_ACK, S_ERR
    } state_t;

    state_t        state;
    logic [2:0]    cnt;
    logic          is_wr;
    logic [DW-1:0] shreg;
    logic [DW-1:0] sh_next;

    // The cast form keeps the shift legal when DW is a single byte.
    assign sh_next  = DW'({shreg, 8'h00});
    assign rx_ready = (state == S_IDLE) || (state == S_ADDR) || (state == S_WDATA);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            is_wr    <= 1'b0;
            shreg    <= '0;
            gb_addr  <= '0;
            gb_wdata <= '0;
            gb_we    <= 1'b0;
            gb_re    <= 1'b0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            gb_we <= 1'b0;
            gb_re <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == OP_WR || rx_data == OP_RD) begin
                            is_wr <= (rx_data == OP_WR);
                            cnt   <= 3'(AB - 1);
                            state <= S_ADDR;
                        end else begin
                            tx_data  <= RSP_ERR;
                            tx_valid <= 1'b1;
                            state    <= S_ERR;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        gb_addr <= AW'({gb_addr, rx_data});
                        if (cnt == 3'd0) begin
                            if (is_wr) begin
                                cnt   <= 3'(DB - 1);
                                state <= S_WDATA;
                            end else begin
                                gb_re <= 1'b1;
                                state <= S_READ;
                            end
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                end
                S_WDATA: begin
                    if (rx_valid) begin
                        gb_wdata <= DW'({gb_wdata, rx_data});
                        if (cnt == 3'd0) begin
                            gb_we <= 1'b1;
                            state <= S_WRITE;
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                end
                S_WRITE: begin
                    tx_data  <= RSP_ACK;
                    tx_valid <= 1'b1;
                    state    <= S_ACK;
                end
                S_READ: begin
                    cnt   <= 3'(RD_LAT - 1);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // cnt hits zero in the cycle RD_LAT after the gb_re cycle
                    if (cnt == 3'd0) begin
                        shreg    <= gb_rdata;
                        tx_data  <= gb_rdata[DW-1 -: 8];
                        tx_valid <= 1'b1;
                        cnt      <= 3'(DB - 1);
                        state    <= S_TX;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_TX: begin
                    if (tx_ready) begin
                        if (cnt == 3'd0) begin
                            tx_valid <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            shreg   <= sh_next;
                            tx_data <= sh_next[DW-1 -: 8];
                            cnt     <= cnt - 3'd1;
                        end
                    end
                end
                S_ACK, S_ERR: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ghostbus_byte_host.sv
// Bench for ghostbus_byte_host: three instances (RD_LAT 2, 1, 7) share one rx
// stream and tx_ready; each has its own exact-latency bus model and tx collector.
module tb_ghostbus_byte_host;
    localparam int N = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic        rx_ready [N];
    logic [7:0]  tx_data  [N];
    logic        tx_valid [N];
    logic [23:0] gb_addr  [N];
    logic [31:0] gb_wdata [N];
    logic [31:0] gb_rdata [N];
    logic        gb_we    [N];
    logic        gb_re    [N];
    logic        busy     [N];

    int checks = 0;
    int errors = 0;
    int tx_mode = 0;

    logic [7:0]  got_q  [N][$];
    logic [55:0] wr_log [N][$];
    int          re_cnt [N];

    task automatic check(string name, int inst, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", name, inst, got, exp);
        end
    endtask

    // Contents of the simulated register space.
    function automatic logic [31:0] bus_val(logic [23:0] a);
        if (a == 24'h000041) return 32'h1234567C;
        return {8'h00, a} * 32'h9E3779B1 + 32'h0BAD5EED;
    endfunction

    always @(posedge clk) begin
        #2;
        case (tx_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 7);

        ghostbus_byte_host #(.AW(24), .DW(32), .RD_LAT(L)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .rx_data  (rx_data),
            .rx_valid (rx_valid),
            .rx_ready (rx_ready[g]),
            .tx_data  (tx_data[g]),
            .tx_valid (tx_valid[g]),
            .tx_ready (tx_ready),
            .gb_addr  (gb_addr[g]),
            .gb_wdata (gb_wdata[g]),
            .gb_we    (gb_we[g]),
            .gb_re    (gb_re[g]),
            .gb_rdata (gb_rdata[g]),
            .busy     (busy[g])
        );

        // Read data is valid only in the single cycle L after the gb_re cycle.
        logic [7:0] re_hist;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) re_hist <= 8'h00;
            else        re_hist <= {re_hist[6:0], gb_re[g]};
        end
        assign gb_rdata[g] = re_hist[L-1] ? bus_val(gb_addr[g]) : (32'hBAD0BAD0 ^ {24'h0, re_hist});

        logic       prev_we = 1'b0;
        logic       prev_re = 1'b0;
        logic       stalled = 1'b0;
        logic [7:0] stall_data = 8'h00;
        always @(negedge clk) begin
            if (gb_we[g] || gb_re[g]) check("strobe_exclusive", g, 32'(gb_we[g] & gb_re[g]), 32'd0);
            if (gb_we[g]) begin
                check("we_single_cycle", g, 32'(prev_we), 32'd0);
                wr_log[g].push_back({gb_addr[g], gb_wdata[g]});
            end
            if (gb_re[g]) begin
                check("re_single_cycle", g, 32'(prev_re), 32'd0);
                re_cnt[g]++;
            end
            prev_we = gb_we[g];
            prev_re = gb_re[g];
            if (stalled) begin
                check("tx_valid_held", g, 32'(tx_valid[g]), 32'd1);
                check("tx_data_held", g, 32'(tx_data[g]), 32'(stall_data));
            end
            stalled    = rst_n && tx_valid[g] && !tx_ready;
            stall_data = tx_data[g];
            if (tx_valid[g] && tx_ready) got_q[g].push_back(tx_data[g]);
        end
    end

    task automatic send_byte(logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!(rx_ready[0] && rx_ready[1] && rx_ready[2])) begin
            @(negedge clk);
            n++;
            if (n > 50) begin
                check("rx_ready_timeout", 0, 32'd0, 32'd1);
                rx_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        rx_valid = 1'b0;
        while (busy[0] || busy[1] || busy[2]) begin
            @(negedge clk);
            n++;
            if (n > 400) begin
                check("idle_timeout", 0, 32'd0, 32'd1);
                return;
            end
        end
    endtask

    task automatic run_frame(logic [7:0] op, logic [23:0] addr, logic [31:0] data,
                             int mode, int exp_n, logic [31:0] exp_resp);
        int wr0 [N];
        int re0 [N];
        tx_mode = mode;
        for (int i = 0; i < N; i++) begin
            got_q[i].delete();
            wr0[i] = wr_log[i].size();
            re0[i] = re_cnt[i];
        end
        send_byte(op);
        if (op == 8'h01 || op == 8'h02)
            for (int k = 2; k >= 0; k--) send_byte(addr[8*k +: 8]);
        if (op == 8'h01)
            for (int k = 3; k >= 0; k--) send_byte(data[8*k +: 8]);
        wait_idle();
        for (int i = 0; i < N; i++) begin
            check("tx_byte_count", i, 32'(got_q[i].size()), 32'(exp_n));
            for (int k = 0; k < exp_n && k < got_q[i].size(); k++)
                check("tx_byte", i, 32'(got_q[i][k]), 32'(exp_resp[8*(exp_n-1-k) +: 8]));
            check("write_count", i, 32'(wr_log[i].size() - wr0[i]), 32'(op == 8'h01));
            check("read_count", i, 32'(re_cnt[i] - re0[i]), 32'(op == 8'h02));
            if (op == 8'h01 && wr_log[i].size() > wr0[i]) begin
                check("write_addr", i, 32'(wr_log[i][wr0[i]][55:32]), 32'(addr));
                check("write_data", i, wr_log[i][wr0[i]][31:0], data);
            end
        end
    endtask

    task automatic check_reset_outputs();
        for (int i = 0; i < N; i++) begin
            check("rst_rx_ready", i, 32'(rx_ready[i]), 32'd1);
            check("rst_busy", i, 32'(busy[i]), 32'd0);
            check("rst_tx_valid", i, 32'(tx_valid[i]), 32'd0);
            check("rst_gb_we", i, 32'(gb_we[i]), 32'd0);
            check("rst_gb_re", i, 32'(gb_re[i]), 32'd0);
            check("rst_gb_addr", i, 32'(gb_addr[i]), 32'd0);
            check("rst_gb_wdata", i, gb_wdata[i], 32'd0);
        end
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [23:0] addr;
        logic [31:0] data;
        int          mode;
        int          exp_n;
        logic [31:0] exp_resp;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t vecs [5];
        int   wr_before [N];
        vecs[0] = '{8'h01, 24'h000040, 32'hDEADBEEF, 0, 1, 32'h000000A5};
        vecs[1] = '{8'h02, 24'h000041, 32'h00000000, 0, 4, 32'h1234567C};
        vecs[2] = '{8'h02, 24'h000041, 32'h00000000, 1, 4, 32'h1234567C};
        vecs[3] = '{8'h7F, 24'h000000, 32'h00000000, 0, 1, 32'h000000EE};
        vecs[4] = '{8'h02, 24'h000041, 32'h00000000, 2, 4, 32'h1234567C};

        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < N; i++) re_cnt[i] = 0;
        #1 rst_n = 1'b0;
        #10 check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs();

        for (int v = 0; v < 5; v++)
            run_frame(vecs[v].op, vecs[v].addr, vecs[v].data, vecs[v].mode, vecs[v].exp_n, vecs[v].exp_resp);

        // Reset landing after two address bytes of a write.
        tx_mode = 0;
        for (int i = 0; i < N; i++) wr_before[i] = wr_log[i].size();
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk);
        rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++)
            check("no_write_after_reset", i, 32'(wr_log[i].size()), 32'(wr_before[i]));
        run_frame(8'h01, 24'h123456, 32'hCAFEF00D, 0, 1, 32'h000000A5);

        for (int r = 0; r < 20; r++) begin
            logic [7:0]  op;
            logic [23:0] addr;
            logic [31:0] data;
            int          sel;
            sel  = $urandom_range(0, 4);
            addr = 24'($urandom);
            data = $urandom;
            if (sel < 2)      op = 8'h01;
            else if (sel < 4) op = 8'h02;
            else              op = 8'($urandom_range(3, 255));
            if (op == 8'h01)      run_frame(op, addr, data, $urandom_range(0, 2), 1, 32'h000000A5);
            else if (op == 8'h02) run_frame(op, addr, data, $urandom_range(0, 2), 4, bus_val(addr));
            else                  run_frame(op, addr, data, $urandom_range(0, 2), 1, 32'h000000EE);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
